i2c_target_responder: RTL

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_target_responder_if.sv | 27 ++
 rtl/i2c_target_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder_if.sv
// rtl/i2c_target_responder_if.sv - bus and host-side signals of the I2C target responder
interface i2c_target_responder_if;
   logic       scl_i;
   logic       sda_i;
   logic       sda_o;
   logic       sda_en_o;
   logic       wr_valid_o;
   logic [7:0] wr_data_o;
   logic       wr_first_o;
   logic       rd_req_o;
   logic [7:0] rd_data_i;
   logic       start_o;
   logic       stop_o;
   logic       busy_o;

   modport slave (
      input  scl_i, sda_i, rd_data_i,
      output sda_o, sda_en_o, wr_valid_o, wr_data_o, wr_first_o,
             rd_req_o, start_o, stop_o, busy_o
   );

   modport master (
      output scl_i, sda_i, rd_data_i,
      input  sda_o, sda_en_o, wr_valid_o, wr_data_o, wr_first_o,
             rd_req_o, start_o, stop_o, busy_o
   );
endinterface

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: address match, write bytes out, read bytes in
module i2c_target_responder #(
   parameter logic [6:0] TargetAddr = 7'h42
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   i2c_target_responder_if.slave   bus
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ADDR      = 3'd1;
   localparam logic [2:0] ADDR_ACK  = 3'd2;
   localparam logic [2:0] WRITE     = 3'd3;
   localparam logic [2:0] WRITE_ACK = 3'd4;
   localparam logic [2:0] READ      = 3'd5;
   localparam logic [2:0] READ_ACK  = 3'd6;
   localparam logic [2:0] WAIT_STOP = 3'd7;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_prev_q, sda_prev_q;
   logic [2:0] state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic       rw_q, rw_d;
   logic       first_q, first_d;
   logic       sda_en_q, sda_en_d;
   logic       wr_valid_q, wr_valid_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       wr_first_q, wr_first_d;
   logic       rd_req_q, rd_req_d;
   logic       start_q, stop_q;
   logic       busy_q, busy_d;

   logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte;

   assign scl       = scl_sync_q[1];
   assign sda       = sda_sync_q[1];
   assign scl_rise  = scl & ~scl_prev_q;
   assign scl_fall  = ~scl & scl_prev_q;
   // SCL must be high in both samples, so a coincident SCL edge masks START/STOP
   assign start_det = ~sda & sda_prev_q & scl & scl_prev_q;
   assign stop_det  = sda & ~sda_prev_q & scl & scl_prev_q;
   assign rx_byte   = {shift_q[6:0], sda};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = rd_req_q ? bus.rd_data_i : tx_q;
      rw_d       = rw_q;
      first_d    = first_q;
      sda_en_d   = sda_en_q;
      wr_valid_d = 1'b0;
      wr_data_d  = wr_data_q;
      wr_first_d = 1'b0;
      rd_req_d   = 1'b0;
      busy_d     = busy_q;
      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_en_d  = 1'b0;
         busy_d    = 1'b1;
      end else if (stop_det) begin
         state_d  = IDLE;
         sda_en_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  rw_d    = sda;
                  first_d = 1'b1;
                  state_d = (rx_byte[7:1] == TargetAddr) ? ADDR_ACK : WAIT_STOP;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               sda_en_d = 1'b1;
            end else if (scl_rise) begin
               bit_cnt_d = 4'd0;
               state_d   = rw_q ? READ : WRITE;
               rd_req_d  = rw_q;
            end
            WRITE: if (scl_fall) begin
               sda_en_d = 1'b0;
            end else if (scl_rise) begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  wr_valid_d = 1'b1;
                  wr_data_d  = rx_byte;
                  wr_first_d = first_q;
                  first_d    = 1'b0;
                  state_d    = WRITE_ACK;
               end
            end
            WRITE_ACK: if (scl_fall) begin
               sda_en_d = 1'b1;
            end else if (scl_rise) begin
               bit_cnt_d = 4'd0;
               state_d   = WRITE;
            end
            READ: if (scl_fall) begin
               if (bit_cnt_q == 4'd8) begin
                  sda_en_d = 1'b0;
                  state_d  = READ_ACK;
               end else begin
                  sda_en_d = ~tx_q[~bit_cnt_q[2:0]];
               end
            end else if (scl_rise) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            READ_ACK: if (scl_rise) begin
               bit_cnt_d = 4'd0;
               state_d   = sda ? WAIT_STOP : READ;
               rd_req_d  = ~sda;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         tx_q       <= 8'd0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         sda_en_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= 8'd0;
         wr_first_q <= 1'b0;
         rd_req_q   <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], bus.scl_i};
         sda_sync_q <= {sda_sync_q[0], bus.sda_i};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
         sda_en_q   <= sda_en_d;
         wr_valid_q <= wr_valid_d;
         wr_data_q  <= wr_data_d;
         wr_first_q <= wr_first_d;
         rd_req_q   <= rd_req_d;
         start_q    <= start_det;
         stop_q     <= stop_det;
         busy_q     <= busy_d;
      end
   end

   assign bus.sda_o      = 1'b0;
   assign bus.sda_en_o   = sda_en_q;
   assign bus.wr_valid_o = wr_valid_q;
   assign bus.wr_data_o  = wr_data_q;
   assign bus.wr_first_o = wr_first_q;
   assign bus.rd_req_o   = rd_req_q;
   assign bus.start_o    = start_q;
   assign bus.stop_o     = stop_q;
   assign bus.busy_o     = busy_q;
endmodule
